// File: rtl/debug_register_bank_pkg.sv
// Shared types and constants for the debug register bank and its dump sequencer.
package debug_register_bank_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

  localparam dump_state_t DUMP_STATE_RST = IDLE;
  localparam int          IDX_RST        = 0;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/debug_register_bank_if.sv
// Write, read and dump-stream signals of the debug register bank.
interface debug_register_bank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2
);
  logic                         wr_en;
  logic [ADDR_WIDTH-1:0]        wr_addr;
  logic [DATA_WIDTH-1:0]        wr_data;
  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
  logic                         dump_start;
  logic                         dump_busy;
  logic                         dump_valid;
  logic                         dump_ready;
  logic [ADDR_WIDTH-1:0]        dump_addr;
  logic [DATA_WIDTH-1:0]        dump_data;
  logic                         dump_done;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, dump_start, dump_ready,
    input  rd_data, dump_busy, dump_valid, dump_addr, dump_data, dump_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, dump_start, dump_ready,
    output rd_data, dump_busy, dump_valid, dump_addr, dump_data, dump_done
  );
endinterface

// File: rtl/debug_register_bank_dump_seq.sv
// Dump sequencer: walks idx over every entry and handshakes each beat out.
// state | meaning
// IDLE  | waiting for dump_start
// LOAD  | array snapshot of entry idx is captured this cycle
// SEND  | beat presented, held until dump_ready
// DONE  | one-cycle completion pulse
module regbank_dump_seq
  import debug_register_bank_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock_debug,
  input  logic                  reset,
  input  logic                  dump_start,
  input  logic                  dump_ready,
  output logic                  dump_busy,
  output logic                  dump_valid,
  output logic                  dump_done,
  output logic [ADDR_WIDTH-1:0] rd_idx,
  output logic                  capture
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(depth_of(ADDR_WIDTH) - 1);

  dump_state_t           state, state_nxt;
  logic [ADDR_WIDTH-1:0] idx, idx_nxt;

  always_ff @(posedge clock_debug or posedge reset) begin
    if (reset) begin
      state <= DUMP_STATE_RST;
      idx   <= ADDR_WIDTH'(IDX_RST);
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: if (dump_start) begin
        idx_nxt   = '0;
        state_nxt = LOAD;
      end
      LOAD: state_nxt = SEND;
      // Termination compares before incrementing so idx never wraps.
      SEND: if (dump_ready) begin
        if (idx == LAST_IDX) begin
          state_nxt = DONE;
        end else begin
          idx_nxt   = idx + 1'b1;
          state_nxt = LOAD;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign dump_busy  = (state != IDLE);
  assign dump_valid = (state == SEND);
  assign dump_done  = (state == DONE);
  assign capture    = (state == LOAD);
  assign rd_idx     = idx;

endmodule

// File: rtl/debug_register_bank.sv
// Debug-domain register bank: NUM_RD registered read ports with write-first
// bypass, optional hard-wired zero entry, and a streaming dump engine.
module debug_register_bank
  import debug_register_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 1
) (
  input logic clock_debug,
  input logic reset,
  debug_register_bank_if.slave bus
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic                             wr_en;
  logic [ADDR_WIDTH-1:0]            wr_addr;
  logic [DATA_WIDTH-1:0]            wr_data;
  logic [ADDR_WIDTH-1:0]            seq_idx;
  logic                             capture;
  logic [ADDR_WIDTH-1:0]            dump_addr_q;
  logic [DATA_WIDTH-1:0]            dump_data_q;

  assign wr_en   = bus.wr_en;
  assign wr_addr = bus.wr_addr;
  assign wr_data = bus.wr_data;

  // Value a read of entry a returns this cycle, including a same-cycle write.
  function automatic logic [DATA_WIDTH-1:0] effective(input logic [ADDR_WIDTH-1:0] a);
    if (ZERO_REG != 0 && a == '0) return '0;
    if (wr_en && wr_addr == a)    return wr_data;
    return mem[a];
  endfunction

  always_ff @(posedge clock_debug or posedge reset) begin
    if (reset) begin
      mem <= '0;
    end else if (wr_en && !(ZERO_REG != 0 && wr_addr == '0)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [DATA_WIDTH-1:0] rd_q;

    always_ff @(posedge clock_debug or posedge reset) begin
      if (reset) rd_q <= '0;
      else       rd_q <= effective(bus.rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]);
    end

    assign bus.rd_data[k*DATA_WIDTH +: DATA_WIDTH] = rd_q;
  end

  regbank_dump_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_dump_seq (
    .clock_debug (clock_debug),
    .reset       (reset),
    .dump_start  (bus.dump_start),
    .dump_ready  (bus.dump_ready),
    .dump_busy   (bus.dump_busy),
    .dump_valid  (bus.dump_valid),
    .dump_done   (bus.dump_done),
    .rd_idx      (seq_idx),
    .capture     (capture)
  );

  always_ff @(posedge clock_debug or posedge reset) begin
    if (reset) begin
      dump_addr_q <= '0;
      dump_data_q <= '0;
    end else if (capture) begin
      dump_addr_q <= seq_idx;
      dump_data_q <= effective(seq_idx);
    end
  end

  assign bus.dump_addr = dump_addr_q;
  assign bus.dump_data = dump_data_q;

endmodule
